count_monitor: RTL and testbench

COUNT_MONITOR -- requirements
Module: count_monitor

---
 rtl/count_monitor_pkg.sv | 19 +
 rtl/count_monitor_sat_counter.sv | 20 ++
 rtl/count_monitor.sv | 91 +++++++++
 tb/tb_count_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_monitor_pkg.sv
// Shared types and helpers for the count monitor.
// Holds the FSM state type, counter width and mod-8 increment.
package count_monitor_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [COUNT_W-1:0] next_count(
        input logic [COUNT_W-1:0] c
    );
        return c + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/count_monitor_sat_counter.sv
// Saturating up-counter used for error and wrap statistics.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (inc && (value != '1)) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Checks that a 3-bit up-counter advances by +1 per valid sample,
// counting sequence errors, wraps and detecting a stuck counter.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int STUCK_LIMIT = 16,
    parameter int ERR_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               count_valid,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_count,
    output logic [ERR_W-1:0]   wrap_count,
    output logic               stuck,
    output logic [COUNT_W-1:0] last_count
);

    localparam logic [7:0] RUN_MAX  = 8'(STUCK_LIMIT);
    localparam logic [7:0] RUN_FLAG = 8'(STUCK_LIMIT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] run;
    logic [7:0] run_next;
    logic       hit;
    logic       same;
    logic       err_inc;
    logic       wrap_inc;

    assign hit      = (count_in == next_count(last_count));
    assign same     = (count_in == last_count);
    assign err_inc  = count_valid && (state == LOCKED) && !hit;
    assign wrap_inc = count_valid && (state == LOCKED) && hit
                      && (count_in == '0);

    always_comb begin
        state_next = state;
        unique case (state)
            HUNT:    state_next = ACQ;
            ACQ:     state_next = hit ? LOCKED : ACQ;
            LOCKED:  state_next = hit ? LOCKED : ACQ;
            default: state_next = HUNT;
        endcase
    end

    // The HUNT capture has no predecessor, so it starts a fresh run.
    always_comb begin
        run_next = '0;
        if (state != HUNT && same) begin
            run_next = (run == RUN_MAX) ? run : run + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            stuck      <= 1'b0;
            last_count <= '0;
            run        <= '0;
        end else begin
            err_pulse <= err_inc;
            if (count_valid) begin
                state      <= state_next;
                locked     <= (state_next == LOCKED);
                last_count <= count_in;
                run        <= run_next;
                stuck      <= (run_next >= RUN_FLAG);
            end
        end
    end

    sat_counter #(.WIDTH(ERR_W)) u_err (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .value (err_count)
    );

    sat_counter #(.WIDTH(ERR_W)) u_wrap (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .value (wrap_count)
    );

endmodule

// File: tb/tb_count_monitor.sv
// Randomized self-checking bench for count_monitor.
// Two instances (ERR_W=8 and ERR_W=2) share one stimulus stream.
module tb_count_monitor;

    localparam int LIMIT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] count_in = '0;
    logic       count_valid = 1'b0;

    logic       locked, err_pulse, stuck;
    logic [7:0] err_count, wrap_count;
    logic [2:0] last_count;
    logic       locked2, err_pulse2, stuck2;
    logic [1:0] err_count2, wrap_count2;
    logic [2:0] last_count2;

    int total = 0;
    int bad   = 0;

    // reference model: plain sequence bookkeeping
    bit m_have;
    bit m_lock;
    bit m_pulse;
    int m_last;
    int m_errs;
    int m_wraps;
    int m_run;

    always #5 clk = ~clk;

    count_monitor #(.STUCK_LIMIT(LIMIT), .ERR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_count   (err_count),
        .wrap_count  (wrap_count),
        .stuck       (stuck),
        .last_count  (last_count)
    );

    count_monitor #(.STUCK_LIMIT(LIMIT), .ERR_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .locked      (locked2),
        .err_pulse   (err_pulse2),
        .err_count   (err_count2),
        .wrap_count  (wrap_count2),
        .stuck       (stuck2),
        .last_count  (last_count2)
    );

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [21:0] exp1();
        return {m_lock, m_pulse, 8'(sat(m_errs, 255)),
                8'(sat(m_wraps, 255)), (m_run >= LIMIT - 1),
                3'(m_last)};
    endfunction

    function automatic logic [9:0] exp2();
        return {m_lock, m_pulse, 2'(sat(m_errs, 3)),
                2'(sat(m_wraps, 3)), (m_run >= LIMIT - 1),
                3'(m_last)};
    endfunction

    function automatic logic [21:0] act1();
        return {locked, err_pulse, err_count, wrap_count,
                stuck, last_count};
    endfunction

    function automatic logic [9:0] act2();
        return {locked2, err_pulse2, err_count2, wrap_count2,
                stuck2, last_count2};
    endfunction

    // Apply one cycle of stimulus and advance the model.
    task automatic drive(input bit v, input int d, input bit r);
        reset       = r;
        count_valid = v;
        count_in    = 3'(d);
        @(posedge clk);
        m_pulse = 0;
        if (r) begin
            m_have = 0; m_lock = 0; m_last = 0;
            m_errs = 0; m_wraps = 0; m_run = 0;
        end else if (v) begin
            if (!m_have) begin
                m_have = 1;
                m_run  = 0;
            end else begin
                if (d == m_last) m_run = sat(m_run + 1, LIMIT);
                else m_run = 0;
                if (d == (m_last + 1) % 8) begin
                    if (m_lock && d == 0 && m_last == 7) m_wraps++;
                    m_lock = 1;
                end else begin
                    if (m_lock) begin
                        m_errs++;
                        m_pulse = 1;
                    end
                    m_lock = 0;
                end
            end
            m_last = d;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 5, 1);
        drive(1, 6, 1);
        total++;
        if (act1() !== 22'd0) begin
            bad++;
            $display("FAIL reset_w8 got=%h want=0", act1());
        end
        total++;
        if (act2() !== 10'd0) begin
            bad++;
            $display("FAIL reset_w2 got=%h want=0", act2());
        end
    endtask

    task automatic test_sequence();
        int pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, i % 8, 0);
            if (err_pulse) pulses++;
            if (i == 0) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL seq_first_unlocked got=%b want=0", locked);
                end
            end
            if (i == 1) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL seq_lock got=%b want=1", locked);
                end
            end
        end
        total++;
        if (wrap_count !== 8'd1 || err_count !== 8'd0 || pulses != 0) begin
            bad++;
            $display("FAIL seq_counts wrap=%0d err=%0d pulses=%0d want 1 0 0",
                     wrap_count, err_count, pulses);
        end
        total++;
        if (act1() !== exp1()) begin
            bad++;
            $display("FAIL seq_model got=%h want=%h", act1(), exp1());
        end
    endtask

    task automatic test_error();
        drive(1, 2, 0);
        drive(1, 3, 0);
        drive(1, 5, 0);
        total++;
        if (err_pulse !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0) begin
            bad++;
            $display("FAIL err_hit pulse=%b cnt=%0d lock=%b want 1 1 0",
                     err_pulse, err_count, locked);
        end
        drive(1, 6, 0);
        total++;
        if (err_pulse !== 1'b0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL err_relock pulse=%b lock=%b want 0 1",
                     err_pulse, locked);
        end
        drive(1, 7, 0);
        total++;
        if (act1() !== exp1()) begin
            bad++;
            $display("FAIL err_model got=%h want=%h", act1(), exp1());
        end
    endtask

    task automatic test_stuck();
        int e0;
        for (int i = 0; i <= 4; i++) drive(1, i, 0);
        e0 = int'(err_count);
        for (int k = 2; k <= 20; k++) begin
            drive(1, 4, 0);
            if (k == 15 || k == 16) begin
                total++;
                if (stuck !== (k == 16)) begin
                    bad++;
                    $display("FAIL stuck_edge k=%0d got=%b want=%b",
                             k, stuck, (k == 16));
                end
            end
            total++;
            if (act1() !== exp1()) begin
                bad++;
                $display("FAIL stuck_model k=%0d got=%h want=%h",
                         k, act1(), exp1());
            end
        end
        total++;
        if (int'(err_count) != e0 + 1) begin
            bad++;
            $display("FAIL stuck_one_err got=%0d want=%0d",
                     err_count, e0 + 1);
        end
        drive(1, 5, 0);
        total++;
        if (stuck !== 1'b0 || locked !== 1'b1) begin
            bad++;
            $display("FAIL stuck_clear stuck=%b lock=%b want 0 1",
                     stuck, locked);
        end
    endtask

    task automatic test_valid_gaps();
        int e0 = int'(err_count);
        int v  = 5;
        int bad_lock = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 0 || i % 4 == 3) begin
                v = (v + 1) % 8;
                drive(1, v, 0);
            end else begin
                drive(0, int'($urandom_range(0, 7)), 0);
            end
            if (locked !== 1'b1) bad_lock++;
        end
        total++;
        if (bad_lock != 0 || int'(err_count) != e0) begin
            bad++;
            $display("FAIL gaps unlocked=%0d err=%0d want 0 %0d",
                     bad_lock, err_count, e0);
        end
        total++;
        if (act1() !== exp1()) begin
            bad++;
            $display("FAIL gaps_model got=%h want=%h", act1(), exp1());
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 1);
        for (int n = 0; n < 5; n++) begin
            drive(1, 1, 0);
            drive(1, 2, 0);
            drive(1, 6, 0);
        end
        total++;
        if (err_count2 !== 2'd3 || err_count !== 8'd5) begin
            bad++;
            $display("FAIL sat err2=%0d err8=%0d want 3 5",
                     err_count2, err_count);
        end
        total++;
        if (act2() !== exp2()) begin
            bad++;
            $display("FAIL sat_model got=%h want=%h", act2(), exp2());
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 0, 1);
        drive(1, 3, 0);
        drive(1, 4, 0);
        drive(1, 0, 0);
        drive(1, 5, 0);
        drive(1, 6, 0);
        drive(1, 2, 0);
        drive(1, 3, 0);
        total++;
        if (err_count !== 8'd2 || locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup err=%0d lock=%b want 2 1",
                     err_count, locked);
        end
        drive(1, 4, 1);
        total++;
        if (act1() !== 22'd0 || act2() !== 10'd0) begin
            bad++;
            $display("FAIL mid_reset got=%h/%h want 0", act1(), act2());
        end
        drive(1, 1, 0);
        total++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || last_count !== 3'd1) begin
            bad++;
            $display("FAIL mid_hunt lock=%b pulse=%b last=%0d want 0 0 1",
                     locked, err_pulse, last_count);
        end
        drive(1, 2, 0);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL mid_relock got=%b want 1", locked);
        end
    endtask

    task automatic test_random();
        int d;
        bit v, r;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 80);
            case ($urandom_range(0, 9))
                0, 1:    d = m_last;
                2:       d = int'($urandom_range(0, 7));
                default: d = (m_last + 1) % 8;
            endcase
            drive(v, d, r);
            total++;
            if (act1() !== exp1() || act2() !== exp2()) begin
                bad++;
                $display("FAIL rand i=%0d got=%h/%h want=%h/%h",
                         i, act1(), act2(), exp1(), exp2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_error();
        test_stuck();
        test_valid_gaps();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
